// File: rtl/alu_pkg.sv
// Shared opcode encodings, FSM state type and flag-register layout for alu_secuencial.
package alu_pkg;

  localparam logic [5:0] OP_ADD = 6'b000001;
  localparam logic [5:0] OP_SUB = 6'b000010;
  localparam logic [5:0] OP_AND = 6'b000011;
  localparam logic [5:0] OP_OR  = 6'b000100;
  localparam logic [5:0] OP_XOR = 6'b000101;
  localparam logic [5:0] OP_LSL = 6'b000110;
  localparam logic [5:0] OP_LSR = 6'b000111;
  localparam logic [5:0] OP_ASR = 6'b001000;
  localparam logic [5:0] OP_MUL = 6'b001001;

  typedef enum logic [1:0] {IDLE, EXEC, MUL} state_t;

  typedef struct packed {
    logic neg;
    logic zero;
    logic carry;
    logic ovf;
  } flags_t;

  function automatic logic is_legal(input logic [5:0] op);
    return (op >= OP_ADD) && (op <= OP_MUL);
  endfunction

endpackage

// File: rtl/adder_substractor.sv
// n-bit adder/subtractor producing carry-out (no-borrow on subtract) and signed overflow.
module adder_substractor #(
  parameter int n = 32
) (
  input  logic [n-1:0] a_i,
  input  logic [n-1:0] b_i,
  input  logic         sub_i,
  output logic [n-1:0] s_o,
  output logic         c_o,
  output logic         v_o
);

  logic [n-1:0] b_eff;

  assign b_eff      = sub_i ? ~b_i : b_i;
  assign {c_o, s_o} = {1'b0, a_i} + {1'b0, b_eff} + {{n{1'b0}}, sub_i};
  assign v_o        = (a_i[n-1] == b_eff[n-1]) && (s_o[n-1] != a_i[n-1]);

endmodule

// File: rtl/mul_iterativo.sv
// Shift-add unsigned multiplier: one multiplier bit per step, full 2n-bit product.
module mul_iterativo #(
  parameter int n = 32
) (
  input  logic           clk,
  input  logic           load_i,
  input  logic           step_i,
  input  logic [n-1:0]   a_i,
  input  logic [n-1:0]   b_i,
  output logic [2*n-1:0] prod_o,
  output logic           fin_o
);

  localparam int CW = $clog2(n) + 1;

  logic [2*n-1:0] mcand_q;
  logic [2*n-1:0] acc_q;
  logic [n-1:0]   mplier_q;
  logic [CW-1:0]  cnt_q;

  always_ff @(posedge clk) begin
    if (load_i) begin
      mcand_q  <= {{n{1'b0}}, a_i};
      mplier_q <= b_i;
      acc_q    <= '0;
      cnt_q    <= '0;
    end else if (step_i) begin
      if (mplier_q[0]) acc_q <= acc_q + mcand_q;
      mcand_q  <= mcand_q << 1;
      mplier_q <= mplier_q >> 1;
      cnt_q    <= cnt_q + 1'b1;
    end
  end

  assign prod_o = acc_q;
  assign fin_o  = (cnt_q == CW'(n));

endmodule

// File: rtl/alu_secuencial.sv
// Clocked ALU with NZCV register, start/busy/done handshake and an iterative multiply path.
module alu_secuencial
  import alu_pkg::*;
#(
  parameter int n   = 32,
  parameter int SHW = $clog2(n)
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  input  logic [5:0]   control,
  input  logic         set_flags,
  input  logic [n-1:0] A,
  input  logic [n-1:0] B,
  output logic         busy,
  output logic         done,
  output logic         error,
  output logic [n-1:0] salida,
  output logic         N,
  output logic         Z,
  output logic         C,
  output logic         V
);

  state_t         state_q, state_d;
  logic [n-1:0]   a_q, a_d, b_q, b_d;
  logic [5:0]     op_q, op_d;
  logic           sf_q, sf_d;
  logic [n-1:0]   salida_q, salida_d;
  flags_t         flags_q, flags_d;
  logic           done_q, done_d, error_q, error_d;

  logic [n-1:0]   add_s;
  logic           add_c, add_v;
  logic [n-1:0]   res;
  logic           res_c, res_v;
  logic [SHW-1:0] amt;
  logic signed [n:0] asr_in;
  logic           mul_load, mul_step, mul_fin;
  logic [2*n-1:0] prod;

  adder_substractor #(.n(n)) u_addsub (
    .a_i(a_q), .b_i(b_q), .sub_i(op_q == OP_SUB),
    .s_o(add_s), .c_o(add_c), .v_o(add_v)
  );

  mul_iterativo #(.n(n)) u_mul (
    .clk(clk), .load_i(mul_load), .step_i(mul_step),
    .a_i(A), .b_i(B), .prod_o(prod), .fin_o(mul_fin)
  );

  assign amt    = b_q[SHW-1:0];
  assign asr_in = {a_q, 1'b0};

  // The extra bit beside each shifted operand captures the last bit shifted out.
  always_comb begin
    res   = '0;
    res_c = 1'b0;
    res_v = 1'b0;
    case (op_q)
      OP_ADD, OP_SUB: begin
        res   = add_s;
        res_c = add_c;
        res_v = add_v;
      end
      OP_AND: res = a_q & b_q;
      OP_OR:  res = a_q | b_q;
      OP_XOR: res = a_q ^ b_q;
      OP_LSL: {res_c, res} = {1'b0, a_q} << amt;
      OP_LSR: {res, res_c} = {a_q, 1'b0} >> amt;
      OP_ASR: {res, res_c} = asr_in >>> amt;
      default: ;
    endcase
  end

  always_comb begin
    state_d  = state_q;
    a_d      = a_q;
    b_d      = b_q;
    op_d     = op_q;
    sf_d     = sf_q;
    salida_d = salida_q;
    flags_d  = flags_q;
    done_d   = 1'b0;
    error_d  = 1'b0;
    mul_load = 1'b0;
    mul_step = 1'b0;
    case (state_q)
      IDLE: begin
        if (start) begin
          a_d      = A;
          b_d      = B;
          op_d     = control;
          sf_d     = set_flags;
          mul_load = (control == OP_MUL);
          state_d  = (control == OP_MUL) ? MUL : EXEC;
        end
      end
      EXEC: begin
        done_d  = 1'b1;
        state_d = IDLE;
        if (is_legal(op_q)) begin
          salida_d = res;
          if (sf_q) flags_d = '{neg: res[n-1], zero: (res == '0), carry: res_c, ovf: res_v};
        end else begin
          salida_d = '0;
          error_d  = 1'b1;
        end
      end
      MUL: begin
        if (mul_fin) begin
          salida_d = prod[n-1:0];
          done_d   = 1'b1;
          state_d  = IDLE;
          if (sf_q) flags_d = '{neg: prod[n-1], zero: (prod[n-1:0] == '0),
                                carry: (prod[2*n-1:n] != '0), ovf: 1'b0};
        end else begin
          mul_step = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      salida_q <= '0;
      flags_q  <= '0;
      done_q   <= 1'b0;
      error_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      salida_q <= salida_d;
      flags_q  <= flags_d;
      done_q   <= done_d;
      error_q  <= error_d;
    end
  end

  // Latched operands are only read while busy, so they need no reset.
  always_ff @(posedge clk) begin
    a_q  <= a_d;
    b_q  <= b_d;
    op_q <= op_d;
    sf_q <= sf_d;
  end

  assign busy   = (state_q != IDLE);
  assign done   = done_q;
  assign error  = error_q;
  assign salida = salida_q;
  assign N      = flags_q.neg;
  assign Z      = flags_q.zero;
  assign C      = flags_q.carry;
  assign V      = flags_q.ovf;

endmodule

// File: tb/tb_alu_secuencial.sv
// Directed bench for alu_secuencial: latency, results, flags, handshake, illegal op and reset abort.
module tb_alu_secuencial;

  logic        clk = 1'b0;
  logic        rst, start, set_flags;
  logic [5:0]  control;
  logic [31:0] A, B;
  logic        busy, done, error;
  logic [31:0] salida;
  logic        N, Z, C, V;

  int n_cmp = 0;
  int n_err = 0;
  int cyc, bcnt, dcnt;

  alu_secuencial #(.n(32)) dut (
    .clk(clk), .rst(rst), .start(start), .control(control), .set_flags(set_flags),
    .A(A), .B(B), .busy(busy), .done(done), .error(error), .salida(salida),
    .N(N), .Z(Z), .C(C), .V(V)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Leaves the bench 1 time unit after the accepting edge, with start already dropped.
  task automatic issue(input logic [5:0] op, input logic [31:0] a, input logic [31:0] b,
                       input logic sf);
    @(negedge clk);
    control = op; A = a; B = b; set_flags = sf; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  task automatic wait_done(output int c, output int bc);
    bc = busy ? 1 : 0;
    c  = 100;
    for (int i = 1; i <= 100; i++) begin
      @(posedge clk); #1;
      if (done) begin
        c = i;
        break;
      end
      if (busy) bc++;
    end
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; set_flags = 1'b0; control = '0; A = '0; B = '0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_salida", salida, 0);
    chk("rst_nzcv", {N, Z, C, V}, 4'b0000);
    chk("rst_ctrl", {busy, done, error}, 3'b000);
    rst = 1'b0;

    issue(6'b000001, 32'hFFFFFFFF, 32'h1, 1'b1);
    wait_done(cyc, bcnt);
    chk("add_lat", cyc, 1);
    chk("add_res", salida, 32'h0);
    chk("add_nzcv", {N, Z, C, V}, 4'b0110);
    @(posedge clk); #1;
    chk("done_pulse", {done, busy}, 2'b00);

    issue(6'b000010, 32'h80000000, 32'h1, 1'b1);
    wait_done(cyc, bcnt);
    chk("sub_res", salida, 32'h7FFFFFFF);
    chk("sub_nzcv", {N, Z, C, V}, 4'b0011);

    issue(6'b000010, 32'h0, 32'h1, 1'b0);
    wait_done(cyc, bcnt);
    chk("sub_nf_res", salida, 32'hFFFFFFFF);
    chk("sub_nf_nzcv", {N, Z, C, V}, 4'b0011);

    issue(6'b001001, 32'd3, 32'd5, 1'b1);
    chk("mul_busy0", busy, 1'b1);
    wait_done(cyc, bcnt);
    chk("mul_lat", cyc, 33);
    chk("mul_busycyc", bcnt, 33);
    chk("mul_res", salida, 32'd15);
    chk("mul_nzcv", {N, Z, C, V}, 4'b0000);

    issue(6'b001001, 32'h00010000, 32'h00010000, 1'b1);
    wait_done(cyc, bcnt);
    chk("mulhi_res", salida, 32'h0);
    chk("mulhi_nzcv", {N, Z, C, V}, 4'b0110);

    issue(6'b000110, 32'h80000001, 32'h1, 1'b1);
    wait_done(cyc, bcnt);
    chk("lsl_res", salida, 32'h00000002);
    chk("lsl_nzcv", {N, Z, C, V}, 4'b0010);

    issue(6'b001000, 32'h80000000, 32'd4, 1'b1);
    wait_done(cyc, bcnt);
    chk("asr_res", salida, 32'hF8000000);
    chk("asr_nzcv", {N, Z, C, V}, 4'b1000);

    issue(6'b000111, 32'h0000000F, 32'h00000020, 1'b1);
    wait_done(cyc, bcnt);
    chk("lsr0_res", salida, 32'h0000000F);
    chk("lsr0_nzcv", {N, Z, C, V}, 4'b0000);

    issue(6'b000111, 32'h0000000F, 32'd2, 1'b1);
    wait_done(cyc, bcnt);
    chk("lsr_res", salida, 32'h00000003);
    chk("lsr_nzcv", {N, Z, C, V}, 4'b0010);

    issue(6'b000101, 32'hFFFF0000, 32'hFF00FF00, 1'b1);
    wait_done(cyc, bcnt);
    chk("xor_res", salida, 32'h00FFFF00);

    issue(6'b000100, 32'h80000000, 32'h00000001, 1'b1);
    wait_done(cyc, bcnt);
    chk("or_res", salida, 32'h80000001);
    chk("or_nzcv", {N, Z, C, V}, 4'b1000);

    issue(6'b001001, 32'd7, 32'd6, 1'b1);
    @(negedge clk);
    control = 6'b000001; A = 32'd1; B = 32'd1; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    chk("ign_busy", {busy, done}, 2'b10);
    wait_done(cyc, bcnt);
    chk("ign_lat", cyc + 1, 33);
    chk("ign_res", salida, 32'd42);
    control = 6'b000011; A = 32'h000000F0; B = 32'h0000003C; set_flags = 1'b1; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    chk("b2b_acc", {busy, done}, 2'b10);
    @(posedge clk); #1;
    chk("b2b_done", done, 1'b1);
    chk("b2b_res", salida, 32'h00000030);

    issue(6'b000010, 32'h80000000, 32'h1, 1'b1);
    wait_done(cyc, bcnt);
    issue(6'b111111, 32'h12345678, 32'h1, 1'b1);
    wait_done(cyc, bcnt);
    chk("ill_lat", cyc, 1);
    chk("ill_err", {done, error}, 2'b11);
    chk("ill_res", salida, 32'h0);
    chk("ill_nzcv", {N, Z, C, V}, 4'b0011);
    @(posedge clk); #1;
    chk("ill_pulse", {done, error}, 2'b00);

    issue(6'b001001, 32'd3, 32'd5, 1'b1);
    repeat (5) @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk); #1;
    chk("abort_ctrl", {busy, done, error}, 3'b000);
    chk("abort_res", salida, 32'h0);
    chk("abort_nzcv", {N, Z, C, V}, 4'b0000);
    rst = 1'b0;
    dcnt = 0;
    for (int i = 0; i < 40; i++) begin
      @(posedge clk); #1;
      if (done || busy) dcnt++;
    end
    chk("abort_quiet", dcnt, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
